lstm_cell_bp: RTL

LSTM_CELL_BP -- requirements
Module: lstm_cell_bp

---
 rtl/lstm_cell_bp.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lstm_cell_bp.sv
// LSTM cell backward pass for one timestep.
// Computes the gate pre-activation deltas and the cell-state gradient for step t-1.
// One signed WIDTHxWIDTH multiplier is reused over 16 fixed steps.
// Each product is shifted right by FRAC and truncated toward minus infinity.
// Optional build macro: LSTM_BP_SAT_EN. When it is defined, shifted products and
// the dc sum saturate to the signed range. When it is undefined, they wrap.
module lstm_cell_bp #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dh,
    input  logic [WIDTH-1:0] i_dc_next,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_i,
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_o,
    input  logic [WIDTH-1:0] i_tanh_c,
    input  logic [WIDTH-1:0] i_c_prev,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_d_a,
    output logic [WIDTH-1:0] o_d_i,
    output logic [WIDTH-1:0] o_d_f,
    output logic [WIDTH-1:0] o_d_o,
    output logic [WIDTH-1:0] o_dc_prev
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
`ifdef LSTM_BP_SAT_EN
    localparam logic [WIDTH-1:0]          WMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]          WMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [3:0] step;

    // operands latched at the start edge
    logic [WIDTH-1:0] r_dh, r_dcn, r_a, r_i, r_f, r_o, r_tc, r_cp;
    // intermediates: square term (tc^2, then a^2), running product, sigmoid slope
    logic [WIDTH-1:0] r_sq, r_p, r_s, r_dc;
    // finished results, copied to the outputs only in DONE
    logic [WIDTH-1:0] r_da, r_di, r_df, r_do, r_dcp;

    logic signed [WIDTH-1:0]   ma, mb;
    logic signed [2*WIDTH-1:0] full, shifted;
    logic [WIDTH:0]            sum_ext;
    logic [WIDTH-1:0]          prod, dc_sum;
    logic                      unused_bits;

    // operand select for the shared multiplier, then scaling, wrap or saturation
    always_comb begin
        ma = '0;
        mb = '0;
        case (step)
            4'd0:  begin ma = r_tc; mb = r_tc;        end
            4'd1:  begin ma = r_dh; mb = r_o;         end
            4'd2:  begin ma = r_p;  mb = ONE - r_sq;  end
            4'd3:  begin ma = r_dh; mb = r_tc;        end
            4'd4:  begin ma = r_o;  mb = ONE - r_o;   end
            4'd5:  begin ma = r_p;  mb = r_s;         end
            4'd6:  begin ma = r_a;  mb = r_a;         end
            4'd7:  begin ma = r_dc; mb = r_i;         end
            4'd8:  begin ma = r_p;  mb = ONE - r_sq;  end
            4'd9:  begin ma = r_i;  mb = ONE - r_i;   end
            4'd10: begin ma = r_dc; mb = r_a;         end
            4'd11: begin ma = r_p;  mb = r_s;         end
            4'd12: begin ma = r_f;  mb = ONE - r_f;   end
            4'd13: begin ma = r_dc; mb = r_cp;        end
            4'd14: begin ma = r_p;  mb = r_s;         end
            default: begin ma = r_dc; mb = r_f;       end
        endcase
        full    = ma * mb;
        shifted = full >>> FRAC;
        sum_ext = {prod[WIDTH-1], prod} + {r_dcn[WIDTH-1], r_dcn};
`ifdef LSTM_BP_SAT_EN
        if (shifted > PMAX)
            prod = WMAX;
        else if (shifted < PMIN)
            prod = WMIN;
        else
            prod = shifted[WIDTH-1:0];
        sum_ext = {prod[WIDTH-1], prod} + {r_dcn[WIDTH-1], r_dcn};
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1])
            dc_sum = sum_ext[WIDTH] ? WMIN : WMAX;
        else
            dc_sum = sum_ext[WIDTH-1:0];
        unused_bits = ^full[FRAC-1:0];
`else
        prod    = shifted[WIDTH-1:0];
        sum_ext = {prod[WIDTH-1], prod} + {r_dcn[WIDTH-1], r_dcn};
        dc_sum  = sum_ext[WIDTH-1:0];
        unused_bits = ^{full[FRAC-1:0], shifted[2*WIDTH-1:WIDTH], sum_ext[WIDTH]};
`endif
    end

    // control FSM, step sequencing, datapath writeback and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            step      <= '0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_d_a     <= '0;
            o_d_i     <= '0;
            o_d_f     <= '0;
            o_d_o     <= '0;
            o_dc_prev <= '0;
            r_dh      <= '0;
            r_dcn     <= '0;
            r_a       <= '0;
            r_i       <= '0;
            r_f       <= '0;
            r_o       <= '0;
            r_tc      <= '0;
            r_cp      <= '0;
            r_sq      <= '0;
            r_p       <= '0;
            r_s       <= '0;
            r_dc      <= '0;
            r_da      <= '0;
            r_di      <= '0;
            r_df      <= '0;
            r_do      <= '0;
            r_dcp     <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        r_dh   <= i_dh;
                        r_dcn  <= i_dc_next;
                        r_a    <= i_a;
                        r_i    <= i_i;
                        r_f    <= i_f;
                        r_o    <= i_o;
                        r_tc   <= i_tanh_c;
                        r_cp   <= i_c_prev;
                        step   <= '0;
                        o_busy <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    case (step)
                        4'd0:  r_sq  <= prod;
                        4'd1:  r_p   <= prod;
                        4'd2:  r_dc  <= dc_sum;
                        4'd3:  r_p   <= prod;
                        4'd4:  r_s   <= prod;
                        4'd5:  r_do  <= prod;
                        4'd6:  r_sq  <= prod;
                        4'd7:  r_p   <= prod;
                        4'd8:  r_da  <= prod;
                        4'd9:  r_s   <= prod;
                        4'd10: r_p   <= prod;
                        4'd11: r_di  <= prod;
                        4'd12: r_s   <= prod;
                        4'd13: r_p   <= prod;
                        4'd14: r_df  <= prod;
                        default: r_dcp <= prod;
                    endcase
                    step <= step + 4'd1;
                    if (step == 4'd15) begin
                        o_busy <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    o_d_a     <= r_da;
                    o_d_i     <= r_di;
                    o_d_f     <= r_df;
                    o_d_o     <= r_do;
                    o_dc_prev <= r_dcp;
                    o_valid   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
